// File: rtl/core_pkg.sv
// Shared pipeline types for the hazard/forwarding slice: forward selects,
// write-back selectors, RV32I major opcodes and the load-use stall FSM states.
package core_pkg;

    typedef enum logic [1:0] {
        ORIGINAL_SELECT   = 2'd0,
        EX_RESULT_SELECT  = 2'd1,
        MEM_RESULT_SELECT = 2'd2
    } forward_mux_code;

    typedef enum logic [1:0] {
        NO_WRITEBACK  = 2'd0,
        ALU_WRITEBACK = 2'd1,
        MEM_WRITEBACK = 2'd2,
        PC4_WRITEBACK = 2'd3
    } write_back_mux_selector;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hazard_state_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    // Bit 0 = rs1 read, bit 1 = rs2 read by the decoding instruction.
    function automatic logic [1:0] operand_use(input logic [6:0] opcode);
        logic [1:0] used;
        used = 2'b00;
        case (opcode)
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: used = 2'b11;
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR:  used = 2'b01;
            default:                                 used = 2'b00;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_sel.sv
// Priority forward select for one source operand: the younger EX/MEM result
// wins over MEM/WB; x0 is never forwarded.
module fwd_operand_sel
    import core_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int MEM_FWD_EN = 1
) (
    input  logic [RA_W-1:0]        rs,
    input  logic                   used,
    input  logic [RA_W-1:0]        ex_mem_dest,
    input  write_back_mux_selector ex_mem_wb_mux,
    input  logic [RA_W-1:0]        mem_wb_dest,
    input  write_back_mux_selector mem_wb_wb_mux,
    output forward_mux_code        sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = (rs == ex_mem_dest) && (ex_mem_wb_mux != NO_WRITEBACK) && (ex_mem_dest != '0);
    assign mem_hit = (rs == mem_wb_dest) && (mem_wb_wb_mux != NO_WRITEBACK) && (mem_wb_dest != '0)
                     && (MEM_FWD_EN != 0);

    // NOTE: sel gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        sel = ORIGINAL_SELECT;
        if (used) begin
            if (ex_hit)       sel = EX_RESULT_SELECT;
            else if (mem_hit) sel = MEM_RESULT_SELECT;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding selects plus load-use stall control for a 5-stage pipeline;
// a load-use hazard stalls decode for LOAD_STALL_CYCLES cycles and is counted.
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int NUM_REGS          = 32,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_FWD_EN        = 1,
    localparam int RA_W             = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             id_opcode_ip,
    input  logic [RA_W-1:0]        id_rs1_ip,
    input  logic [RA_W-1:0]        id_rs2_ip,
    input  logic [6:0]             id_ex_opcode_ip,
    input  logic [RA_W-1:0]        id_ex_dest_ip,
    input  logic [RA_W-1:0]        EX_MEM_dest_ip,
    input  logic [RA_W-1:0]        MEM_WB_dest_ip,
    input  write_back_mux_selector EX_MEM_wb_mux_ip,
    input  write_back_mux_selector MEM_WB_wb_mux_ip,
    input  logic                   flush_ip,
    output forward_mux_code        fa_mux_op,
    output forward_mux_code        fb_mux_op,
    output logic                   stall_op,
    output logic                   bubble_op,
    output logic [15:0]            hazard_cnt_op
);

    localparam int CNT_W = 3;

    hazard_state_e    state;
    logic [CNT_W-1:0] remain;
    logic [1:0]       rs_used;
    logic             load_use;
    logic             hazard;

    assign rs_used = operand_use(id_opcode_ip);

    // Selects are forced to ORIGINAL_SELECT while reset is held.
    fwd_operand_sel #(.RA_W(RA_W), .MEM_FWD_EN(MEM_FWD_EN)) u_sel_a (
        .rs            (id_rs1_ip),
        .used          (rs_used[0] && !reset),
        .ex_mem_dest   (EX_MEM_dest_ip),
        .ex_mem_wb_mux (EX_MEM_wb_mux_ip),
        .mem_wb_dest   (MEM_WB_dest_ip),
        .mem_wb_wb_mux (MEM_WB_wb_mux_ip),
        .sel           (fa_mux_op)
    );

    fwd_operand_sel #(.RA_W(RA_W), .MEM_FWD_EN(MEM_FWD_EN)) u_sel_b (
        .rs            (id_rs2_ip),
        .used          (rs_used[1] && !reset),
        .ex_mem_dest   (EX_MEM_dest_ip),
        .ex_mem_wb_mux (EX_MEM_wb_mux_ip),
        .mem_wb_dest   (MEM_WB_dest_ip),
        .mem_wb_wb_mux (MEM_WB_wb_mux_ip),
        .sel           (fb_mux_op)
    );

    assign load_use = (id_ex_opcode_ip == OPCODE_LOAD) && (id_ex_dest_ip != '0)
                      && ((rs_used[0] && (id_rs1_ip == id_ex_dest_ip))
                       || (rs_used[1] && (id_rs2_ip == id_ex_dest_ip)));

    // New hazards are only recognised from IDLE; flush squashes everything.
    assign hazard    = (state == IDLE) && load_use;
    assign stall_op  = !reset && !flush_ip && ((state == STALL) || hazard);
    assign bubble_op = stall_op;

    // NOTE: all state here updates with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remain        <= '0;
            hazard_cnt_op <= '0;
        end else if (flush_ip) begin
            state  <= IDLE;
            remain <= '0;
        end else if (state == IDLE) begin
            if (hazard) begin
                if (hazard_cnt_op != 16'hFFFF) hazard_cnt_op <= hazard_cnt_op + 16'd1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state  <= STALL;
                    remain <= CNT_W'(LOAD_STALL_CYCLES - 1);
                end
            end
        end else begin
            if (remain <= CNT_W'(1)) begin
                state  <= IDLE;
                remain <= '0;
            end else begin
                remain <= remain - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench: three configurations share one stimulus stream and are
// compared every cycle against a remaining-stall-cycles model, plus literal pins.
module tb_hazard_fwd_unit;
    import core_pkg::*;

    localparam int N = 3;
    localparam int LSC [N] = '{1, 3, 2};
    localparam int MFE [N] = '{1, 1, 0};

    logic                   clk = 1'b0;
    logic                   reset;
    logic [6:0]             id_opcode;
    logic [4:0]             id_rs1, id_rs2;
    logic [6:0]             id_ex_opcode;
    logic [4:0]             id_ex_dest, ex_mem_dest, mem_wb_dest;
    write_back_mux_selector ex_mem_wb, mem_wb_wb;
    logic                   flush;

    forward_mux_code fa [N];
    forward_mux_code fb [N];
    logic            stall [N];
    logic            bubble [N];
    logic [15:0]     cnt [N];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_left [N] = '{0, 0, 0};
    int m_cnt  [N] = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NUM_REGS(32), .LOAD_STALL_CYCLES(1), .MEM_FWD_EN(1)) u_lsc1 (
        .clk(clk), .reset(reset), .id_opcode_ip(id_opcode), .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2),
        .id_ex_opcode_ip(id_ex_opcode), .id_ex_dest_ip(id_ex_dest), .EX_MEM_dest_ip(ex_mem_dest),
        .MEM_WB_dest_ip(mem_wb_dest), .EX_MEM_wb_mux_ip(ex_mem_wb), .MEM_WB_wb_mux_ip(mem_wb_wb),
        .flush_ip(flush), .fa_mux_op(fa[0]), .fb_mux_op(fb[0]), .stall_op(stall[0]),
        .bubble_op(bubble[0]), .hazard_cnt_op(cnt[0]));

    hazard_fwd_unit #(.NUM_REGS(32), .LOAD_STALL_CYCLES(3), .MEM_FWD_EN(1)) u_lsc3 (
        .clk(clk), .reset(reset), .id_opcode_ip(id_opcode), .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2),
        .id_ex_opcode_ip(id_ex_opcode), .id_ex_dest_ip(id_ex_dest), .EX_MEM_dest_ip(ex_mem_dest),
        .MEM_WB_dest_ip(mem_wb_dest), .EX_MEM_wb_mux_ip(ex_mem_wb), .MEM_WB_wb_mux_ip(mem_wb_wb),
        .flush_ip(flush), .fa_mux_op(fa[1]), .fb_mux_op(fb[1]), .stall_op(stall[1]),
        .bubble_op(bubble[1]), .hazard_cnt_op(cnt[1]));

    hazard_fwd_unit #(.NUM_REGS(32), .LOAD_STALL_CYCLES(2), .MEM_FWD_EN(0)) u_nomem (
        .clk(clk), .reset(reset), .id_opcode_ip(id_opcode), .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2),
        .id_ex_opcode_ip(id_ex_opcode), .id_ex_dest_ip(id_ex_dest), .EX_MEM_dest_ip(ex_mem_dest),
        .MEM_WB_dest_ip(mem_wb_dest), .EX_MEM_wb_mux_ip(ex_mem_wb), .MEM_WB_wb_mux_ip(mem_wb_wb),
        .flush_ip(flush), .fa_mux_op(fa[2]), .fb_mux_op(fb[2]), .stall_op(stall[2]),
        .bubble_op(bubble[2]), .hazard_cnt_op(cnt[2]));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit reads_rs1();
        return id_opcode inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE,
                                 OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR};
    endfunction

    function automatic bit reads_rs2();
        return id_opcode inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE};
    endfunction

    function automatic bit model_load_use();
        if (id_ex_opcode != OPCODE_LOAD || id_ex_dest == 0) return 1'b0;
        return (reads_rs1() && id_rs1 == id_ex_dest) || (reads_rs2() && id_rs2 == id_ex_dest);
    endfunction

    function automatic forward_mux_code model_sel(input logic [4:0] rs, input bit used, input int mem_en);
        if (reset || !used) return ORIGINAL_SELECT;
        if (ex_mem_wb != NO_WRITEBACK && ex_mem_dest != 0 && rs == ex_mem_dest) return EX_RESULT_SELECT;
        if (mem_en != 0 && mem_wb_wb != NO_WRITEBACK && mem_wb_dest != 0 && rs == mem_wb_dest)
            return MEM_RESULT_SELECT;
        return ORIGINAL_SELECT;
    endfunction

    always @(posedge clk) begin
        bit hz;
        hz = model_load_use();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_left[i] = 0;
                m_cnt[i]  = 0;
            end else if (flush) begin
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
            end else if (hz) begin
                if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
                m_left[i] = LSC[i] - 1;
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                bit exp_stall;
                exp_stall = !reset && !flush && (m_left[i] > 0 || model_load_use());
                check($sformatf("model_fa[%0d]", i), 32'(fa[i]), 32'(model_sel(id_rs1, reads_rs1(), MFE[i])));
                check($sformatf("model_fb[%0d]", i), 32'(fb[i]), 32'(model_sel(id_rs2, reads_rs2(), MFE[i])));
                check($sformatf("model_stall[%0d]", i), 32'(stall[i]), 32'(exp_stall));
                check($sformatf("model_bubble[%0d]", i), 32'(bubble[i]), 32'(exp_stall));
                check($sformatf("model_cnt[%0d]", i), 32'(cnt[i]), 32'(m_cnt[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        id_opcode    = OPCODE_LUI;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_ex_opcode = OPCODE_OP;
        id_ex_dest   = 5'd0;
        ex_mem_dest  = 5'd0;
        mem_wb_dest  = 5'd0;
        ex_mem_wb    = NO_WRITEBACK;
        mem_wb_wb    = NO_WRITEBACK;
        flush        = 1'b0;
    endtask

    initial begin
        set_quiet();
        reset = 1'b1;
        // Forwarding match and load-use hazard present while reset is held.
        id_opcode = OPCODE_OP; id_rs1 = 5'd5; id_rs2 = 5'd3;
        ex_mem_dest = 5'd5; ex_mem_wb = ALU_WRITEBACK;
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3;
        step();
        check("reset_stall", 32'(stall[1]), 32'd0);
        check("reset_fa", 32'(fa[0]), 32'(ORIGINAL_SELECT));
        check("reset_cnt", 32'(cnt[1]), 32'd0);
        step();
        set_quiet();
        reset = 1'b0;
        step();

        // EX/MEM on rs1, MEM/WB on rs2
        id_opcode = OPCODE_OP; id_rs1 = 5'd5; id_rs2 = 5'd6;
        ex_mem_dest = 5'd5; ex_mem_wb = ALU_WRITEBACK;
        mem_wb_dest = 5'd6; mem_wb_wb = MEM_WRITEBACK;
        #1;
        check("fwd_ex_fa", 32'(fa[0]), 32'(EX_RESULT_SELECT));
        check("fwd_mem_fb", 32'(fb[0]), 32'(MEM_RESULT_SELECT));
        check("fwd_nostall", 32'(stall[0]), 32'd0);
        check("fwd_mem_disabled", 32'(fb[2]), 32'(ORIGINAL_SELECT));
        step();

        // Both later stages write x7: EX/MEM wins; rs2 unused for OPIMM
        id_opcode = OPCODE_OPIMM; id_rs1 = 5'd7; id_rs2 = 5'd7;
        ex_mem_dest = 5'd7; mem_wb_dest = 5'd7;
        #1;
        check("prio_fa", 32'(fa[1]), 32'(EX_RESULT_SELECT));
        check("unused_fb", 32'(fb[1]), 32'(ORIGINAL_SELECT));
        step();
        id_opcode = OPCODE_OP;
        #1;
        check("same_rs_fb", 32'(fb[0]), 32'(EX_RESULT_SELECT));
        step();
        ex_mem_wb = NO_WRITEBACK;
        #1;
        check("mem_only_fa", 32'(fa[0]), 32'(MEM_RESULT_SELECT));
        step();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_mem_dest = 5'd0; mem_wb_dest = 5'd0;
        ex_mem_wb = ALU_WRITEBACK;
        #1;
        check("x0_fa", 32'(fa[0]), 32'(ORIGINAL_SELECT));
        check("x0_fb", 32'(fb[0]), 32'(ORIGINAL_SELECT));
        step();
        set_quiet();
        step();

        // Load-use hazard: LOAD x3 in ID/EX, ADD x?,x1,x3 in decode
        id_opcode = OPCODE_OP; id_rs1 = 5'd1; id_rs2 = 5'd3;
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3;
        #1;
        check("lu_c1_stall1", 32'(stall[0]), 32'd1);
        check("lu_c1_bubble1", 32'(bubble[0]), 32'd1);
        check("lu_c1_cnt_pre", 32'(cnt[0]), 32'd0);
        check("lu_c1_stall3", 32'(stall[1]), 32'd1);
        step();
        id_ex_opcode = OPCODE_OP; id_ex_dest = 5'd0;   // bubble now in ID/EX
        #1;
        check("lu_c2_stall1", 32'(stall[0]), 32'd0);
        check("lu_c2_cnt1", 32'(cnt[0]), 32'd1);
        check("lu_c2_stall3", 32'(stall[1]), 32'd1);
        step();
        check("lu_c3_stall3", 32'(stall[1]), 32'd1);
        step();
        check("lu_c4_stall3", 32'(stall[1]), 32'd0);
        check("lu_c4_cnt3", 32'(cnt[1]), 32'd1);
        step();

        // Flush in stall cycle 2
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3;
        #1;
        check("fl_c1_stall3", 32'(stall[1]), 32'd1);
        step();
        id_ex_opcode = OPCODE_OP; id_ex_dest = 5'd0; flush = 1'b1;
        #1;
        check("fl_c2_stall3", 32'(stall[1]), 32'd0);
        check("fl_c2_bubble3", 32'(bubble[1]), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_c3_idle", 32'(stall[1]), 32'd0);
        check("fl_cnt3", 32'(cnt[1]), 32'd2);
        step();

        // Hazard coincident with flush
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3; flush = 1'b1;
        #1;
        check("flhz_stall3", 32'(stall[1]), 32'd0);
        check("flhz_stall1", 32'(stall[0]), 32'd0);
        step();
        flush = 1'b0; id_ex_opcode = OPCODE_OP; id_ex_dest = 5'd0;
        #1;
        check("flhz_cnt3", 32'(cnt[1]), 32'd2);
        check("flhz_cnt1", 32'(cnt[0]), 32'd2);
        step();

        // Reset in stall cycle 2
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3;
        #1;
        check("rs_c1_stall3", 32'(stall[1]), 32'd1);
        step();
        id_ex_opcode = OPCODE_OP; id_ex_dest = 5'd0;
        #1;
        check("rs_c2_stall3", 32'(stall[1]), 32'd1);
        reset = 1'b1;
        #1;
        check("rs_during_stall3", 32'(stall[1]), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rs_after_stall3", 32'(stall[1]), 32'd0);
        check("rs_after_cnt3", 32'(cnt[1]), 32'd0);
        step();

        // Saturation: a hazard every cycle for the single-cycle configuration
        id_ex_opcode = OPCODE_LOAD; id_ex_dest = 5'd3;
        repeat (70000) step();
        check("sat_cnt1", 32'(cnt[0]), 32'h0000_FFFF);
        step();
        check("sat_hold1", 32'(cnt[0]), 32'h0000_FFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_quiet();
        step();
        check("sat_after_flush1", 32'(cnt[0]), 32'h0000_FFFF);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_REGS, default 32: architectural register count; register-address width RA_W = $clog2(NUM_REGS).
REQ-003 Parameter LOAD_STALL_CYCLES, default 1, legal 1..4: total stall cycles per load-use hazard.
REQ-004 Parameter MEM_FWD_EN, default 1: 0 disables MEM_RESULT_SELECT, so any MEM/WB match yields ORIGINAL_SELECT.
REQ-005 Ports, clock and reset first:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- id_opcode_ip  in  7  opcode of the instruction in decode
- id_rs1_ip / id_rs2_ip  in  RA_W  decode source registers
- id_ex_opcode_ip  in  7  opcode held in ID/EX
- id_ex_dest_ip  in  RA_W  ID/EX destination
- EX_MEM_dest_ip / MEM_WB_dest_ip  in  RA_W  later-stage destinations
- EX_MEM_wb_mux_ip / MEM_WB_wb_mux_ip  in  write_back_mux_selector  NO_WRITEBACK = no register write
- flush_ip  in  1  taken branch/jump squash
- fa_mux_op / fb_mux_op  out  forward_mux_code  rs1/rs2 operand select
- stall_op  out  1  hold PC and IF/ID
- bubble_op  out  1  inject NOP into ID/EX
- hazard_cnt_op  out  16  count of load-use stall events

Function
REQ-006 Operand use by decode opcode: OP, BRANCH, STORE use rs1 and rs2; OPIMM, LOAD, JALR use rs1 only; LUI, AUIPC, JAL and all others use none.
REQ-007 The select for a used operand SHALL be EX_RESULT_SELECT when rs == EX_MEM_dest_ip, EX/MEM writes, and dest != 0.
REQ-008 Otherwise it SHALL be MEM_RESULT_SELECT when rs == MEM_WB_dest_ip, MEM/WB writes, dest != 0, and MEM_FWD_EN = 1.
REQ-009 In all other cases, and for unused operands, the select SHALL be ORIGINAL_SELECT.
REQ-010 Forward selects SHALL be combinational, with zero-cycle latency.
REQ-011 A load-use hazard SHALL be raised when all of the following hold:
- id_ex_opcode_ip == OPCODE_LOAD
- id_ex_dest_ip != 0
- id_ex_dest_ip equals a used source of the decode instruction
REQ-012 FSM states are IDLE and STALL, held in typedef hazard_state_e.
REQ-013 In IDLE, hazard with flush_ip = 0:
- stall_op = bubble_op = 1 in the same cycle (combinational)
- hazard_cnt_op increments at the clock edge
- if LOAD_STALL_CYCLES > 1, next state is STALL and the remaining-cycle counter loads LOAD_STALL_CYCLES-1
REQ-014 In STALL:
- stall_op = bubble_op = 1
- the counter decrements each cycle
- the state returns to IDLE in the cycle after the counter reaches 1
- no new hazard is detected and the counter does not increment
REQ-015 With LOAD_STALL_CYCLES = 1, STALL SHALL never be entered; the stall lasts one cycle and ends naturally when the load leaves ID/EX.
REQ-016 flush_ip = 1 SHALL force stall_op = bubble_op = 0 that cycle and send the FSM to IDLE with the counter at 0; flush beats a simultaneous hazard and does not increment hazard_cnt_op.
REQ-017 hazard_cnt_op SHALL saturate at 16'hFFFF.
REQ-018 Forward selects SHALL remain valid (per REQ-007..009) during stall cycles.
REQ-019 With id_rs1_ip == id_rs2_ip, both selects SHALL be identical when both operands are used.

Reset
REQ-020 Reset values:
- FSM = IDLE, counter = 0, hazard_cnt_op = 0
- stall_op = bubble_op = 0 while reset = 1
- fa_mux_op = fb_mux_op = ORIGINAL_SELECT while reset = 1
REQ-021 Reset asserted mid-STALL SHALL abort the stall at the next edge without incrementing.

Structure
REQ-022 CORE_PKG SHALL hold:
- forward_mux_code, write_back_mux_selector
- opcode constants, including OPCODE_LOAD, BRANCH, STORE, JALR
- hazard_state_e
REQ-023 Per-operand priority select SHALL be sub-module fwd_operand_sel, instantiated twice; the FSM and counters stay in hazard_fwd_unit.

Verification
REQ-024 OP rs1=5, rs2=6; EX_MEM dest=5 writes; MEM_WB dest=6 writes -> fa=EX_RESULT_SELECT, fb=MEM_RESULT_SELECT, stall_op=0.
REQ-025 EX_MEM and MEM_WB both dest=7 writing; OPIMM rs1=7 -> fa=EX_RESULT_SELECT; fb=ORIGINAL_SELECT; dest=0 variant -> both ORIGINAL_SELECT.
REQ-026 LOAD_STALL_CYCLES=1: LOAD x3 in ID/EX, ADD rs2=3 in decode -> stall_op=bubble_op=1 for exactly 1 cycle, hazard_cnt_op 0->1.
REQ-027 LOAD_STALL_CYCLES=3: same hazard -> stall asserted 3 consecutive cycles, FSM back in IDLE on the 4th cycle.
REQ-028 LOAD_STALL_CYCLES=3: flush_ip pulses in stall cycle 2 -> stall_op=0 that cycle, IDLE next; hazard coincident with flush -> no stall, count unchanged.
REQ-029 Reset during stall cycle 2 -> outputs at reset values next cycle; 70000 hazard events -> hazard_cnt_op holds 16'hFFFF.
